// File: rtl/multicycle_control.sv
// Purpose  : Moore control FSM for a multicycle MIPS datapath with a shared ALU and a shared memory.
// Latency  : FETCH through retire takes 5 cycles for lw, 4 for sw/R-type/addi, 3 for beq/j and 2 for an illegal opcode.
// Backpress: none; the FSM advances on every clock and the datapath has no stall input.
// Ports    : clk, reset (async, active-high); opcode/funct/zero come from IR and the ALU;
//            PCEn/IRWrite/MemWrite/RegWrite are enables and strobes; IorD/MemToReg/RegDst/ALUSrcA/
//            ALUSrcB/PCSrc are mux selects; AluControl is the ALU function; state and instret are for debug.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCEn,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             IorD,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [2:0]       AluControl,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur;
    logic   retire;

    assign state = cur;

    // The last state of every legal instruction retires it. All of these states go back to FETCH.
    always_comb begin
        retire = 1'b0;
        case (cur)
            S_MEMWB, S_MEMWR, S_ALUWB, S_BEQEX, S_ADDIWB, S_JEX: retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= S_FETCH;
            instret <= '0;
        end else begin
            case (cur)
                S_FETCH:  cur <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: cur <= S_MEMADR;
                        OP_RTYPE:     cur <= S_EXECUTE;
                        OP_BEQ:       cur <= S_BEQEX;
                        OP_ADDI:      cur <= S_ADDIEX;
                        OP_J:         cur <= S_JEX;
                        default:      cur <= S_FETCH;   // unknown opcode: drop it, no retire
                    endcase
                end
                // DECODE only lets lw and sw reach this state, so any opcode other than sw takes the load path.
                S_MEMADR:  cur <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   cur <= S_MEMWB;
                S_EXECUTE: cur <= S_ALUWB;
                S_ADDIEX:  cur <= S_ADDIWB;
                default:   cur <= S_FETCH;   // writeback/branch/jump states, plus recovery from codes 12-15
            endcase
            if (retire) begin
                instret <= instret + CNT_W'(1);   // wraps silently
            end
        end
    end

    always_comb begin
        PCEn       = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IorD       = 1'b0;
        MemToReg   = 1'b0;
        RegDst     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        AluControl = 3'b000;
        case (cur)
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                AluControl = 3'b010;
                IRWrite    = 1'b1;
                PCEn       = 1'b1;
            end
            S_DECODE: begin
                // Compute the branch target early. ALUOut holds it when BEQEX runs.
                ALUSrcB    = 2'b11;
                AluControl = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                AluControl = 3'b010;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                case (funct)
                    6'b100010: AluControl = 3'b110;
                    6'b100100: AluControl = 3'b000;
                    6'b100101: AluControl = 3'b001;
                    6'b101010: AluControl = 3'b111;
                    default:   AluControl = 3'b010;   // add, and the fallback for any other funct
                endcase
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BEQEX: begin
                ALUSrcA    = 1'b1;
                AluControl = 3'b110;
                PCSrc      = 2'b01;
                PCEn       = zero;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JEX: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: ;
        endcase
        // Reset puts the state at FETCH. No enable or strobe may fire while reset is held.
        if (reset) begin
            PCEn     = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    opcode, funct;
    logic          zero;
    logic          PCEn, IRWrite, MemWrite, RegWrite, IorD, MemToReg, RegDst, ALUSrcA;
    logic [1:0]    ALUSrcB, PCSrc;
    logic [2:0]    AluControl;
    logic [3:0]    state;
    logic [CW-1:0] instret;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .PCEn(PCEn), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IorD(IorD), .MemToReg(MemToReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .AluControl(AluControl),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    // Bit order: PCEn IRWrite MemWrite RegWrite | IorD MemToReg RegDst ALUSrcA | ALUSrcB PCSrc | AluControl
    logic [14:0] obs;
    assign obs = {PCEn, IRWrite, MemWrite, RegWrite, IorD, MemToReg, RegDst, ALUSrcA,
                  ALUSrcB, PCSrc, AluControl};

    logic [14:0] tbl [12];   // control word of each step, transcribed from the state descriptions
    int vectors = 0;
    int miscompares = 0;
    int exp_cnt = 0;         // reference count of retired instructions, modulo 2**CW

    // Instruction classes: 0 lw, 1 sw, 2 R-type, 3 beq, 4 addi, 5 j, 6 illegal
    function automatic logic [5:0] op_of(input int cls);
        logic [5:0] r;
        case (cls)
            0: r = 6'b100011;
            1: r = 6'b101011;
            2: r = 6'b000000;
            3: r = 6'b000100;
            4: r = 6'b001000;
            5: r = 6'b000010;
            default: begin
                r = 6'($urandom);
                while (r inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
                    r = 6'($urandom);
            end
        endcase
        return r;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Runs one instruction starting in FETCH. Opcode, funct and zero carry junk in every step that must
    // not look at them. With abort set, reset is raised in the middle of the MEMWR step.
    task automatic run_instr(input int cls, input logic z, input logic [5:0] fn, input logic abort);
        int seq[$];
        logic [5:0] op;
        logic [14:0] e;
        op = op_of(cls);
        case (cls)
            0: seq = '{0, 1, 2, 3, 4};
            1: seq = '{0, 1, 2, 5};
            2: seq = '{0, 1, 6, 7};
            3: seq = '{0, 1, 8};
            4: seq = '{0, 1, 9, 10};
            5: seq = '{0, 1, 11};
            default: seq = '{0, 1};
        endcase
        foreach (seq[k]) begin
            int s;
            s = seq[k];
            opcode = (s == 1 || s == 2) ? op : 6'($urandom);
            funct  = (s == 6) ? fn : 6'($urandom);
            zero   = (s == 8) ? z : 1'($urandom);
            #1;
            e = tbl[s];
            if (s == 6) e[2:0] = alu_of(fn);
            if (s == 8) e[14] = z;
            chk($sformatf("state c%0d k%0d", cls, k), 32'(state), 32'(s));
            chk($sformatf("ctrl c%0d k%0d", cls, k), 32'(obs), 32'(e));
            chk($sformatf("instret c%0d k%0d", cls, k), 32'(instret), 32'(exp_cnt));
            if (abort && s == 5) begin
                reset = 1'b1;
                #1;
                chk("rst_memwr_strobe", 32'(MemWrite), 32'd0);
                chk("rst_memwr_state", 32'(state), 32'd0);
                chk("rst_memwr_ctrl", 32'(obs), 32'(tbl[0] & 15'h0FFF));
                chk("rst_memwr_instret", 32'(instret), 32'd0);
                exp_cnt = 0;
                @(posedge clk);
                #1 chk("rst_hold_strobes", 32'(obs[14:11]), 32'd0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (cls != 6) exp_cnt = (exp_cnt + 1) % (1 << CW);
    endtask

    initial begin
        tbl[0]  = 15'b1100_0000_01_00_010;
        tbl[1]  = 15'b0000_0000_11_00_010;
        tbl[2]  = 15'b0000_0001_10_00_010;
        tbl[3]  = 15'b0000_1000_00_00_000;
        tbl[4]  = 15'b0001_0100_00_00_000;
        tbl[5]  = 15'b0010_1000_00_00_000;
        tbl[6]  = 15'b0000_0001_00_00_010;
        tbl[7]  = 15'b0001_0010_00_00_000;
        tbl[8]  = 15'b0000_0001_00_01_110;
        tbl[9]  = 15'b0000_0001_10_00_010;
        tbl[10] = 15'b0001_0000_00_00_000;
        tbl[11] = 15'b1000_0000_00_10_000;

        // Reset held for 3 cycles. Enables stay low and the selects show their FETCH values.
        reset = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_state", 32'(state), 32'd0);
            chk("reset_ctrl", 32'(obs), 32'(tbl[0] & 15'h0FFF));
            chk("reset_instret", 32'(instret), 32'd0);
        end
        reset = 1'b0;

        // Directed cases. The first FETCH after release checks IRWrite=1 and PCEn=1.
        run_instr(0, 1'b0, 6'b0, 1'b0);          // lw
        run_instr(2, 1'b0, 6'b100010, 1'b0);     // sub
        run_instr(2, 1'b0, 6'b101010, 1'b0);     // slt
        run_instr(1, 1'b0, 6'b0, 1'b0);          // sw
        run_instr(3, 1'b1, 6'b0, 1'b0);          // beq taken
        run_instr(3, 1'b0, 6'b0, 1'b0);          // beq not taken
        run_instr(6, 1'b0, 6'b0, 1'b0);          // illegal opcode
        run_instr(5, 1'b0, 6'b0, 1'b0);          // j
        run_instr(4, 1'b0, 6'b0, 1'b0);          // addi
        run_instr(1, 1'b0, 6'b0, 1'b1);          // sw, aborted by reset in MEMWR

        // Random program. It retires well over 2**CW instructions, so instret wraps several times.
        for (int i = 0; i < 80; i++) begin
            int c;
            logic [5:0] f;
            c = int'($urandom_range(0, 6));
            case ($urandom_range(0, 5))
                0: f = 6'b100000;
                1: f = 6'b100010;
                2: f = 6'b100100;
                3: f = 6'b100101;
                4: f = 6'b101010;
                default: f = 6'($urandom);
            endcase
            run_instr(c, 1'($urandom), f, 1'b0);
        end

        // The wrap must be exact: retire legal instructions until the count is all-ones, then one more gives 0.
        while (exp_cnt != (1 << CW) - 1) run_instr(5, 1'b0, 6'b0, 1'b0);
        run_instr(3, 1'b1, 6'b0, 1'b0);
        #1 chk("instret_wrap", 32'(instret), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
